// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM states, RV32I width codes, byte-enable patterns.
// Optional watchdog is enabled by defining LSU_TIMEOUT_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Stores only know B/H/W; loads reject the three unused codes.
    function automatic logic f3_illegal(input logic wr,
                                        input logic [2:0] f3);
        logic bad;
        if (wr)
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            bad = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load lane select and sign/zero extension.
// Purely combinational; word is the raw memory read data.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane, then extend according to width code.
    always_comb begin
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   data = {24'd0, lane_b};
            F3_HU:   data = {16'd0, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding word-bus access per request.
// Define LSU_TIMEOUT_EN to add the Mem_Ack watchdog.
module lsu
    import lsu_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LSU_Req,
    input  logic              LSU_Write,
    input  logic [2:0]        LSU_Funct3,
    input  logic [DWIDTH-1:0] LSU_Addr,
    input  logic [DWIDTH-1:0] LSU_Store_Data,
    output logic              LSU_Busy,
    output logic              LSU_Done,
    output logic [DWIDTH-1:0] LSU_Load_Data,
    output logic              LSU_Misaligned,
    output logic              LSU_Fault,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [DWIDTH-1:0] Mem_Addr,
    output logic [DWIDTH-1:0] Mem_Wdata,
    output logic [3:0]        Mem_Be,
    input  logic              Mem_Ack,
    input  logic [DWIDTH-1:0] Mem_Rdata
);

    state_t            state, state_nx;
    logic [DWIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [DWIDTH-1:0] wdata_d, ext_data;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q;
    logic              we_q, mis_q, fault_q;
    logic              illegal, misal, timeout;

    // Decode the incoming request: legality, alignment, lanes.
    always_comb begin
        illegal = f3_illegal(LSU_Write, LSU_Funct3);
        case (LSU_Funct3[1:0])
            2'b01: begin
                misal   = LSU_Addr[0];
                be_d    = BE_H << LSU_Addr[1:0];
                wdata_d = {2{LSU_Store_Data[15:0]}};
            end
            2'b10: begin
                misal   = |LSU_Addr[1:0];
                be_d    = BE_W;
                wdata_d = LSU_Store_Data;
            end
            default: begin
                misal   = 1'b0;
                be_d    = BE_B << LSU_Addr[1:0];
                wdata_d = {4{LSU_Store_Data[7:0]}};
            end
        endcase
        if (!LSU_Write)
            be_d = BE_W;
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign timeout = (wd_cnt == 8'(TIMEOUT - 1));

    // Watchdog: counts ACCESS cycles that pass without an ack.
    always_ff @(posedge Clk) begin
        if (Reset)
            wd_cnt <= 8'd0;
        else if (state == IDLE)
            wd_cnt <= 8'd0;
        else if (state == ACCESS && !Mem_Ack)
            wd_cnt <= wd_cnt + 8'd1;
    end
`else
    // TIMEOUT has no effect without the watchdog.
    logic unused_timeout;
    assign unused_timeout = ^(8'(TIMEOUT));
    assign timeout        = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (LSU_Req)
                    state_nx = (illegal || misal) ? ERR : ACCESS;
            ACCESS:
                if (Mem_Ack)
                    state_nx = RESP;
                else if (timeout)
                    state_nx = ERR;
            default:
                state_nx = IDLE;
        endcase
    end

    // Request capture and read-data capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 4'd0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            if (state == IDLE && LSU_Req) begin
                addr_q  <= LSU_Addr;
                wdata_q <= wdata_d;
                be_q    <= be_d;
                f3_q    <= LSU_Funct3;
                we_q    <= LSU_Write;
                fault_q <= illegal;
                mis_q   <= !illegal && misal;
            end
            if (state == ACCESS) begin
                if (Mem_Ack) begin
                    rdata_q <= Mem_Rdata;
                end else if (timeout) begin
                    fault_q <= 1'b1;
                    mis_q   <= 1'b0;
                end
            end
        end
    end

    lsu_load_ext u_ext (
        .word   (rdata_q),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    // Bus and pipeline outputs, all derived from state.
    always_comb begin
        LSU_Busy       = (state != IDLE);
        Mem_Req        = (state == ACCESS);
        Mem_We         = Mem_Req && we_q;
        Mem_Addr       = Mem_Req ? {addr_q[DWIDTH-1:2], 2'b00} : '0;
        Mem_Wdata      = Mem_Req ? wdata_q : '0;
        Mem_Be         = Mem_Req ? be_q : 4'd0;
        LSU_Done       = (state == RESP) || (state == ERR);
        LSU_Load_Data  = (state == RESP && !we_q) ? ext_data : '0;
        LSU_Misaligned = (state == ERR) && mis_q;
        LSU_Fault      = (state == ERR) && fault_q;
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus queues expected bus requests
// and completions; a negedge monitor pops and compares them.
module tb_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int TO     = 4;
    localparam int HOLD_K = 3;
`else
    localparam int TO     = 255;
    localparam int HOLD_K = 10;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        LSU_Req = 1'b0;
    logic        LSU_Write = 1'b0;
    logic [2:0]  LSU_Funct3 = 3'd0;
    logic [31:0] LSU_Addr = 32'd0;
    logic [31:0] LSU_Store_Data = 32'd0;
    logic        LSU_Busy, LSU_Done, LSU_Misaligned, LSU_Fault;
    logic [31:0] LSU_Load_Data;
    logic        Mem_Req, Mem_We;
    logic [31:0] Mem_Addr, Mem_Wdata;
    logic [3:0]  Mem_Be;
    logic        Mem_Ack = 1'b0;
    logic [31:0] Mem_Rdata = 32'd0;

    lsu #(.DWIDTH(32), .TIMEOUT(TO)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .LSU_Req        (LSU_Req),
        .LSU_Write      (LSU_Write),
        .LSU_Funct3     (LSU_Funct3),
        .LSU_Addr       (LSU_Addr),
        .LSU_Store_Data (LSU_Store_Data),
        .LSU_Busy       (LSU_Busy),
        .LSU_Done       (LSU_Done),
        .LSU_Load_Data  (LSU_Load_Data),
        .LSU_Misaligned (LSU_Misaligned),
        .LSU_Fault      (LSU_Fault),
        .Mem_Req        (Mem_Req),
        .Mem_We         (Mem_We),
        .Mem_Addr       (Mem_Addr),
        .Mem_Wdata      (Mem_Wdata),
        .Mem_Be         (Mem_Be),
        .Mem_Ack        (Mem_Ack),
        .Mem_Rdata      (Mem_Rdata)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        fault;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    resp_t rsp_q[$];
    mreq_t mem_q[$];
    resp_t r;
    mreq_t m;
    int    checks = 0;
    int    failures = 0;
    int    busy_cnt = 0;
    int    acc_cnt = 0;
    logic  req_d = 1'b0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Monitor: counts busy cycles and accesses, checks handshakes.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (LSU_Busy)
                busy_cnt++;
            if (Mem_Req && !req_d)
                acc_cnt++;
            if (Mem_Req && Mem_Ack) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_addr", Mem_Addr, m.addr);
                    chk("mem_be", 32'(Mem_Be), 32'(m.be));
                    chk("mem_we", 32'(Mem_We), 32'(m.we));
                    if (m.we)
                        chk("mem_wdata", Mem_Wdata, m.wdata);
                end
            end
            if (LSU_Done) begin
                if (rsp_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("load_data", LSU_Load_Data, r.data);
                    chk("misaligned", 32'(LSU_Misaligned), 32'(r.mis));
                    chk("fault", 32'(LSU_Fault), 32'(r.fault));
                end
            end
        end
        req_d = Mem_Req;
    end

    // One request; ack in cycle k after the request cycle.
    task automatic op(input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] sd,
                      input logic [31:0] rdata, input int k,
                      input logic err, input logic hold,
                      input logic [31:0] exp_data,
                      input logic exp_mis, input logic exp_fault,
                      input logic [31:0] exp_addr,
                      input logic [3:0] exp_be,
                      input logic [31:0] exp_wdata);
        resp_t er;
        mreq_t em;
        int    a0;
        int    b0;
        er.data  = exp_data;
        er.mis   = exp_mis;
        er.fault = exp_fault;
        rsp_q.push_back(er);
        if (!err) begin
            em.addr  = exp_addr;
            em.be    = exp_be;
            em.we    = wr;
            em.wdata = exp_wdata;
            mem_q.push_back(em);
        end
        @(posedge Clk); #1;
        a0 = acc_cnt;
        b0 = busy_cnt;
        LSU_Req        = 1'b1;
        LSU_Write      = wr;
        LSU_Funct3     = f3;
        LSU_Addr       = addr;
        LSU_Store_Data = sd;
        @(posedge Clk); #1;
        if (hold) begin
            LSU_Addr       = 32'h0000_03FC;
            LSU_Store_Data = 32'h5555_5555;
        end else begin
            LSU_Req = 1'b0;
        end
        if (!err) begin
            repeat (k - 1) begin
                @(posedge Clk); #1;
            end
            Mem_Ack   = 1'b1;
            Mem_Rdata = rdata;
            @(posedge Clk); #1;
            Mem_Ack   = 1'b0;
            Mem_Rdata = 32'd0;
            LSU_Req   = 1'b0;
        end
        @(posedge Clk); #1;
        chk("access_count", 32'(acc_cnt - a0), err ? 32'd0 : 32'd1);
        chk("busy_cycles", 32'(busy_cnt - b0),
            err ? 32'd1 : 32'(k + 1));
    endtask

    initial begin
        int b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(LSU_Busy), 32'd0);
        chk("rst_done", 32'(LSU_Done), 32'd0);
        chk("rst_mem_req", 32'(Mem_Req), 32'd0);
        chk("rst_mem_be", 32'(Mem_Be), 32'd0);
        chk("rst_mem_addr", Mem_Addr, 32'd0);
        chk("rst_load_data", LSU_Load_Data, 32'd0);
        chk("rst_flags", 32'({LSU_Fault, LSU_Misaligned, Mem_We}), 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Ack while idle must do nothing.
        b0 = busy_cnt;
        Mem_Ack   = 1'b1;
        Mem_Rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(posedge Clk); #1;
        end
        Mem_Ack   = 1'b0;
        Mem_Rdata = 32'd0;
        @(posedge Clk); #1;
        chk("idle_ack_busy", 32'(busy_cnt - b0), 32'd0);

        // wr f3 addr sd rdata k err hold | data mis fault addr be wdata
        op(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 0, 0,
           32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 0);
        op(0, 3'b000, 32'h103, 0, 32'h80112233, 2, 0, 0,
           32'hFFFFFF80, 0, 0, 32'h100, 4'b1111, 0);
        op(0, 3'b100, 32'h103, 0, 32'h80112233, 1, 0, 0,
           32'h00000080, 0, 0, 32'h100, 4'b1111, 0);
        op(0, 3'b001, 32'h102, 0, 32'h80112233, 1, 0, 0,
           32'hFFFF8011, 0, 0, 32'h100, 4'b1111, 0);
        op(0, 3'b101, 32'h102, 0, 32'h80112233, 3, 0, 0,
           32'h00008011, 0, 0, 32'h100, 4'b1111, 0);
        op(0, 3'b000, 32'h101, 0, 32'h00007F00, 1, 0, 0,
           32'h0000007F, 0, 0, 32'h100, 4'b1111, 0);
        op(1, 3'b001, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 1, 0, 0,
           32'h0, 0, 0, 32'h200, 4'b1100, 32'hABCDABCD);
        op(1, 3'b000, 32'h201, 32'h12345678, 32'hFFFFFFFF, 2, 0, 0,
           32'h0, 0, 0, 32'h200, 4'b0010, 32'h78787878);
        op(1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1, 0, 0,
           32'h0, 0, 0, 32'h204, 4'b1111, 32'hCAFEF00D);
        op(0, 3'b010, 32'h101, 0, 0, 1, 1, 0,
           32'h0, 1, 0, 0, 0, 0);
        op(0, 3'b011, 32'h100, 0, 0, 1, 1, 0,
           32'h0, 0, 1, 0, 0, 0);
        op(1, 3'b001, 32'h203, 32'h1234, 0, 1, 1, 0,
           32'h0, 1, 0, 0, 0, 0);
        op(1, 3'b101, 32'h101, 32'h1234, 0, 1, 1, 0,
           32'h0, 0, 1, 0, 0, 0);
        op(0, 3'b010, 32'h300, 0, 32'h11223344, HOLD_K, 0, 1,
           32'h11223344, 0, 0, 32'h300, 4'b1111, 0);

        // Reset in the middle of an access aborts it silently.
        @(posedge Clk); #1;
        LSU_Req    = 1'b1;
        LSU_Write  = 1'b0;
        LSU_Funct3 = 3'b010;
        LSU_Addr   = 32'h400;
        @(posedge Clk); #1;
        LSU_Req = 1'b0;
        @(negedge Clk);
        chk("pre_rst_mem_req", 32'(Mem_Req), 32'd1);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("post_rst_mem_req", 32'(Mem_Req), 32'd0);
        chk("post_rst_busy", 32'(LSU_Busy), 32'd0);
        chk("post_rst_done", 32'(LSU_Done), 32'd0);
        Reset = 1'b0;
        repeat (2) begin
            @(posedge Clk); #1;
        end

`ifdef LSU_TIMEOUT_EN
        // No ack: the watchdog ends the access after TO cycles.
        begin
            resp_t er;
            er.data  = 32'd0;
            er.mis   = 1'b0;
            er.fault = 1'b1;
            rsp_q.push_back(er);
            b0 = busy_cnt;
            LSU_Req    = 1'b1;
            LSU_Write  = 1'b0;
            LSU_Funct3 = 3'b010;
            LSU_Addr   = 32'h500;
            @(posedge Clk); #1;
            LSU_Req = 1'b0;
            repeat (TO) begin
                @(posedge Clk); #1;
            end
            @(posedge Clk); #1;
            chk("timeout_busy", 32'(busy_cnt - b0), 32'(TO + 1));
            chk("timeout_mem_req", 32'(Mem_Req), 32'd0);
        end
`endif

        repeat (2) begin
            @(posedge Clk); #1;
        end
        chk("rsp_pending", 32'(rsp_q.size()), 32'd0);
        chk("mem_pending", 32'(mem_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
